// File: rtl/ext_bus_pkg.sv
// Shared types and default geometry for the MACPU external bus arbiter.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/ext_bus_rr_pick.sv
// Two-way round-robin selector: with both requesting, the one not served last wins.
module ext_bus_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Arbitrates the external pin bus between the CPU core (0) and a DMA master (1),
// sequencing each access as ADDR, WAIT_CYCLES wait phases, then DONE.
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [1:0]          i_req,
  input  logic [1:0]          i_we,
  input  logic [1:0]          i_lock_req,
  input  logic [2*ADDR_W-1:0] i_addr,
  input  logic [2*DATA_W-1:0] i_wdata,
  output logic [1:0]          o_gnt,
  output logic [1:0]          o_ack,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rw,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_data_oe,
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_lock,
  output logic                o_lock_oe,
  input  logic                i_lock,
  output logic [1:0]          o_state
);

  // Handshake: a requester raises i_req with its we/addr/wdata/lock_req stable
  // and keeps it up until it sees its o_ack pulse. Everything is latched at
  // grant, so a request withdrawn mid-access still completes and acks.

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                owner_q, last_q, we_q, lock_q;
  logic [1:0]          gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [1:0]          pick, grant_vec;
  logic                grant_fire, release_fire, wait_last, sel;

  ext_bus_rr_pick u_pick (
    .req  (i_req),
    .last (last_q),
    .gnt  (pick)
  );

  assign wait_last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign sel       = grant_vec[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    grant_vec    = 2'b00;
    grant_fire   = 1'b0;
    release_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // While we hold the lock only the owner may be granted; it gives the
        // lock up by idling with neither req nor lock_req.
        if (lock_q) begin
          if (i_req[owner_q])             grant_vec = owner_q ? 2'b10 : 2'b01;
          else if (!i_lock_req[owner_q])  release_fire = 1'b1;
        end else if (!i_lock) begin
          grant_vec = pick;
        end
        grant_fire = |grant_vec;
        if (grant_fire) state_d = ST_ADDR;
      end
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: if (wait_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      lock_q  <= 1'b0;
      gnt_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant_fire) begin
        gnt_q   <= grant_vec;
        owner_q <= sel;
        last_q  <= sel;
        we_q    <= i_we[sel];
        lock_q  <= i_lock_req[sel];
        addr_q  <= sel ? i_addr[2*ADDR_W-1:ADDR_W]   : i_addr[ADDR_W-1:0];
        wdata_q <= sel ? i_wdata[2*DATA_W-1:DATA_W] : i_wdata[DATA_W-1:0];
      end
      if (release_fire) begin
        lock_q <= 1'b0;
        gnt_q  <= 2'b00;
        last_q <= owner_q;
      end
      if (state_q == ST_DONE && !lock_q) gnt_q <= 2'b00;
      if (state_q == ST_ADDR) cnt_q <= '0;
      else if (state_q == ST_WAIT && !wait_last) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == ST_WAIT && wait_last && !we_q) rdata_q <= i_data;
    end
  end

  // Pin outputs come only from registers, so the state reset drops oe at once.
  assign o_gnt     = gnt_q;
  assign o_ack     = (state_q == ST_DONE) ? gnt_q : 2'b00;
  assign o_rdata   = rdata_q;
  assign o_rw      = we_q;
  assign o_addr    = addr_q;
  assign o_data    = wdata_q;
  assign o_data_oe = we_q && (state_q == ST_ADDR || state_q == ST_WAIT);
  assign o_lock    = lock_q;
  assign o_lock_oe = lock_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: per-cycle vector table plus hand-written
// sequences for external lock, reset mid-access and back-to-back round-robin.
module tb_ext_bus_arbiter;
  import ext_bus_pkg::*;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lreq;
    logic [15:0] pdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_ack;
    logic        e_oe;
    logic        e_rw;
    logic        e_lock;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic [15:0] e_rdata;
    logic        chk_bus;
    logic        chk_rd;
  } vec_t;

  logic        clk, n_rst;
  logic [1:0]  req, we, lreq;
  logic [15:0] addr0, addr1, wdata0, wdata1, pdata;
  logic        ext_lock, pin_lock;
  logic [1:0]  gnt, ack, state;
  logic [15:0] rdata, paddr, pdout;
  logic        rw, data_oe, lock, lock_oe;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  vec_t vecs[$];

  assign pin_lock = ext_lock | (lock_oe & lock);

  ext_bus_arbiter dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_req      (req),
    .i_we       (we),
    .i_lock_req (lreq),
    .i_addr     ({addr1, addr0}),
    .i_wdata    ({wdata1, wdata0}),
    .o_gnt      (gnt),
    .o_ack      (ack),
    .o_rdata    (rdata),
    .o_rw       (rw),
    .o_addr     (paddr),
    .o_data     (pdout),
    .o_data_oe  (data_oe),
    .i_data     (pdata),
    .o_lock     (lock),
    .o_lock_oe  (lock_oe),
    .i_lock     (pin_lock),
    .o_state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req   = v.req;
    we    = v.we;
    lreq  = v.lreq;
    pdata = v.pdata;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d_gnt", i), 32'(gnt), 32'(v.e_gnt));
    chk($sformatf("r%0d_ack", i), 32'(ack), 32'(v.e_ack));
    chk($sformatf("r%0d_oe", i), 32'(data_oe), 32'(v.e_oe));
    chk($sformatf("r%0d_lock", i), 32'({lock, lock_oe}), 32'({v.e_lock, v.e_lock}));
    if (v.chk_bus) begin
      chk($sformatf("r%0d_rw", i), 32'(rw), 32'(v.e_rw));
      chk($sformatf("r%0d_addr", i), 32'(paddr), 32'(v.e_addr));
      if (v.e_oe) chk($sformatf("r%0d_data", i), 32'(pdout), 32'(v.e_data));
    end
    if (v.chk_rd) chk($sformatf("r%0d_rdata", i), 32'(rdata), 32'(v.e_rdata));
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                              input logic [15:0] pd, input logic [1:0] eg, input logic [1:0] ea,
                              input logic eo, input logic erw, input logic el,
                              input logic [15:0] ead, input logic [15:0] edt, input logic [15:0] erd,
                              input logic cb, input logic cr);
    vec_t v;
    v.req = r; v.we = w; v.lreq = l; v.pdata = pd;
    v.e_gnt = eg; v.e_ack = ea; v.e_oe = eo; v.e_rw = erw; v.e_lock = el;
    v.e_addr = ead; v.e_data = edt; v.e_rdata = erd; v.chk_bus = cb; v.chk_rd = cr;
    return v;
  endfunction

  initial begin
    int n;
    int acks;
    int cyc;
    int prev;

    n_rst = 1'b0; req = 2'b00; we = 2'b00; lreq = 2'b00; pdata = 16'h0; ext_lock = 1'b0;
    addr0 = 16'h1234; addr1 = 16'h00F0; wdata0 = 16'h1111; wdata1 = 16'hA5A5;

    // Read by requester 0, ack in cycle 4 with the data sampled in cycle 3.
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0, 16'h0,    0, 0));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 0, 0, 0, 16'h1234, 16'h0, 16'h0,    1, 0));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 0, 0, 0, 16'h1234, 16'h0, 16'h0,    1, 0));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 16'hBEEF, 2'b01, 2'b00, 0, 0, 0, 16'h1234, 16'h0, 16'h0,    1, 0));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b01, 0, 0, 0, 16'h1234, 16'h0, 16'hBEEF, 1, 1));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0, 16'h0,    0, 0));
    // Write by requester 1; rdata must keep the previous read value.
    vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h0000, 2'b10, 2'b00, 1, 1, 0, 16'h00F0, 16'hA5A5, 16'h0,    1, 0));
    vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h0000, 2'b10, 2'b00, 1, 1, 0, 16'h00F0, 16'hA5A5, 16'h0,    1, 0));
    vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h5555, 2'b10, 2'b00, 1, 1, 0, 16'h00F0, 16'hA5A5, 16'h0,    1, 0));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 2'b10, 2'b10, 0, 1, 0, 16'h00F0, 16'h0,    16'hBEEF, 1, 1));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0));
    // Three locked reads by requester 0 while requester 1 waits.
    for (int a = 1; a <= 3; a++) begin
      if (a == 1) vecs.push_back(mk(2'b11, 2'b00, 2'b01, 16'h0, 2'b00, 2'b00, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0));
      else        vecs.push_back(mk(2'b11, 2'b00, 2'b01, 16'h0, 2'b01, 2'b00, 0, 0, 1, 16'h0, 16'h0, 16'h0, 0, 0));
      vecs.push_back(mk(2'b11, 2'b00, 2'b01, 16'h0, 2'b01, 2'b00, 0, 0, 1, 16'h1234, 16'h0, 16'h0, 1, 0));
      vecs.push_back(mk(2'b11, 2'b00, 2'b01, 16'h0, 2'b01, 2'b00, 0, 0, 1, 16'h1234, 16'h0, 16'h0, 1, 0));
      vecs.push_back(mk(2'b11, 2'b00, 2'b01, 16'(a), 2'b01, 2'b00, 0, 0, 1, 16'h1234, 16'h0, 16'h0, 1, 0));
      if (a < 3) vecs.push_back(mk(2'b11, 2'b00, 2'b01, 16'h0, 2'b01, 2'b01, 0, 0, 1, 16'h1234, 16'h0, 16'(a), 1, 1));
      else       vecs.push_back(mk(2'b10, 2'b00, 2'b00, 16'h0, 2'b01, 2'b01, 0, 0, 1, 16'h1234, 16'h0, 16'(a), 1, 1));
    end
    // Release cycle, then requester 1 is granted.
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 0, 0, 1, 16'h0,    16'h0, 16'h0,    0, 0));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0, 16'h0,    0, 0));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 16'h0000, 2'b10, 2'b00, 0, 0, 0, 16'h00F0, 16'h0, 16'h0,    1, 0));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 16'h0000, 2'b10, 2'b00, 0, 0, 0, 16'h00F0, 16'h0, 16'h0,    1, 0));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 16'h4321, 2'b10, 2'b00, 0, 0, 0, 16'h00F0, 16'h0, 16'h0,    1, 0));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 2'b10, 2'b10, 0, 0, 0, 16'h00F0, 16'h0, 16'h4321, 1, 1));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0, 16'h0,    0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_outs", 32'({gnt, ack, rw, data_oe, lock, lock_oe}), 32'(0));
    chk("rst_bus", 32'({paddr, pdout}), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    n_rst = 1'b1;

    // Vector table: check this cycle's outputs, then drive this cycle's inputs.
    for (int i = 0; i < vecs.size(); i++) begin
      check_row(i, vecs[i]);
      drive(vecs[i]);
      tick();
    end

    // External lock blocks new grants; a grant follows the cycle it falls.
    req = 2'b01; we = 2'b00; lreq = 2'b00; ext_lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("xlock_nogrant%0d", k), 32'({gnt, state}), 32'({2'b00, ST_IDLE}));
    end
    ext_lock = 1'b0;
    tick();
    chk("xlock_grant", 32'(gnt), 32'(2'b01));
    ext_lock = 1'b1;  // an in-flight access must still complete
    n = 0;
    while (ack != 2'b01 && n < 8) begin
      tick();
      n++;
    end
    chk("xlock_ack_cycles", 32'(n), 32'(3));
    req = 2'b00; ext_lock = 1'b0;
    tick();
    chk("xlock_idle_gnt", 32'(gnt), 32'(2'b00));

    // Reset during a write WAIT phase: oe drops asynchronously, no ack follows.
    req = 2'b01; we = 2'b01;
    tick();
    tick();
    chk("mrst_wait_state", 32'(state), 32'(ST_WAIT));
    chk("mrst_oe_before", 32'(data_oe), 32'(1));
    #3 n_rst = 1'b0;
    #1;
    chk("mrst_oe_async", 32'(data_oe), 32'(0));
    chk("mrst_gnt_async", 32'({gnt, ack, state}), 32'(0));
    req = 2'b00; we = 2'b00;
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mrst_quiet%0d", k), 32'({gnt, ack, data_oe, state}), 32'(0));
      tick();
    end

    // Both requesters held: acks alternate 0,1,0,1, first at cycle 4 then every 5.
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    req = 2'b11; we = 2'b00; lreq = 2'b00;
    acks = 0; cyc = 0; prev = 0;
    while (acks < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (ack != 2'b00) begin
        chk($sformatf("rr_ack%0d", acks), 32'(ack), 32'(exp_q.pop_front()));
        if (acks == 0) chk("rr_first_latency", 32'(cyc), 32'(4));
        else           chk($sformatf("rr_spacing%0d", acks), 32'(cyc - prev), 32'(5));
        prev = cyc;
        acks++;
        if (acks == 4) req = 2'b00;
      end
    end
    chk("rr_ack_count", 32'(acks), 32'(4));
    chk("rr_queue_empty", 32'(exp_q.size()), 32'(0));
    tick();
    chk("rr_idle_gnt", 32'(gnt), 32'(2'b00));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
